// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, round constants and GF(2^8) helpers.
// Pure declarations; no timing or flow-control behaviour of its own.
package aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;
  typedef enum logic {IDLE, RUN} ks_state_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on one 32-bit word.
// Combinational, zero latency; no handshake.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] a,
  output logic [31:0] c
);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    s_box u_s_box (
      .a (a[8*i +: 8]),
      .c (c[8*i +: 8])
    );
  end

endmodule

// File: rtl/s_box.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
// Purely combinational; no handshake.
module s_box
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] c
);

  // a^254 is the inverse for a!=0 and maps 0 to 0, which the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] e;
    r = 8'h01;
    p = x;
    e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv = gf_inv(a);
    c   = inv
        ^ {inv[6:0], inv[7]}
        ^ {inv[5:0], inv[7:6]}
        ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]}
        ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: rk0 one cycle after key accept, then one round key per cycle.
// rk_ready low freezes rk_data/rk_idx/rk_valid; abort returns to idle and keeps rk_data.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  input  logic         abort,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         rk_last
);

  if (NR != 10) begin : g_nr_check
    $error("aes_key_expand: only NR=10 (AES-128) is supported");
  end

  localparam logic [3:0] LAST = 4'(NR);

  ks_state_t  state;
  ks_state_t  state_d;
  aes_block_t data_d;
  logic [3:0] idx_d;

  aes_word_t  w0, w1, w2, w3;
  aes_word_t  sub_out;
  aes_word_t  t, n0, n1, n2, n3;
  logic [3:0] rcon_idx;
  logic [7:0] rcon_byte;

  assign w0 = rk_data[127:96];
  assign w1 = rk_data[95:64];
  assign w2 = rk_data[63:32];
  assign w3 = rk_data[31:0];

  aes_sub_word u_sub_word (
    .a (rot_word(w3)),
    .c (sub_out)
  );

  // Round constant for the key being produced, i.e. index rk_idx+1.
  assign rcon_idx = rk_idx + 4'd1;

  always_comb begin
    rcon_byte = 8'h00;
    if (rcon_idx >= 4'd1 && rcon_idx <= 4'd10) rcon_byte = RCON[rcon_idx];
  end

  assign t  = sub_out ^ {rcon_byte, 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_ready = (state == IDLE);
  assign rk_valid  = (state == RUN);
  assign rk_last   = rk_valid && (rk_idx == LAST);

  always_comb begin
    state_d = state;
    data_d  = rk_data;
    idx_d   = rk_idx;
    if (abort) begin
      state_d = IDLE;
      idx_d   = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            state_d = RUN;
            data_d  = key_in;
            idx_d   = 4'd0;
          end
        end
        RUN: begin
          if (rk_ready) begin
            if (rk_idx == LAST) begin
              state_d = IDLE;
            end else begin
              data_d = {n0, n1, n2, n3};
              idx_d  = rk_idx + 4'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rk_data <= '0;
      rk_idx  <= '0;
    end else begin
      state   <= state_d;
      rk_data <= data_d;
      rk_idx  <= idx_d;
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 word-recurrence model plus directed scenarios.
module tb_aes_key_expand;

  typedef logic [10:0][127:0] sched_t;

  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ZERO = 128'h0;
  localparam logic [127:0] KEY_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         abort;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         rk_last;

  int n_checks = 0;
  int n_err    = 0;

  aes_key_expand #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .abort     (abort),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_data   (rk_data),
    .rk_idx    (rk_idx),
    .rk_last   (rk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] cst;
    inv = 8'h00;
    cst = 8'h63;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++) if (m_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
    return s;
  endfunction

  function automatic logic [31:0] m_subw(input logic [31:0] w);
    return {m_sbox(w[31:24]), m_sbox(w[23:16]), m_sbox(w[15:8]), m_sbox(w[7:0])};
  endfunction

  function automatic sched_t expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    sched_t      s;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = m_subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = m_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction

  // Protocol model: predicts what the DUT shows after each rising edge.
  bit           armed   = 0;
  bit           m_run   = 0;
  bit           m_known = 0;
  int           m_idx   = 0;
  logic [127:0] m_data  = '0;
  sched_t       m_sched;
  bit           stall_prev = 0;
  logic [127:0] stall_data;
  logic [3:0]   stall_idx;

  always @(negedge clk) begin
    if (armed) begin
      chk("rk_valid", 128'(rk_valid), 128'(m_run));
      chk("key_ready", 128'(key_ready), 128'(!m_run));
      chk("rk_last", 128'(rk_last), 128'(m_run && m_idx == 10));
      if (m_run || m_known) begin
        chk("rk_idx", 128'(rk_idx), 128'(m_idx));
        chk("rk_data", rk_data, m_data);
      end
      if (stall_prev) begin
        chk("stall_data", rk_data, stall_data);
        chk("stall_idx", 128'(rk_idx), 128'(stall_idx));
      end
    end
    stall_prev = (rk_valid === 1'b1) && (rk_ready === 1'b0) && (abort === 1'b0) && (rst_n === 1'b1);
    stall_data = rk_data;
    stall_idx  = rk_idx;
    if (rst_n !== 1'b1) begin
      m_run = 0; m_idx = 0; m_data = '0; m_known = 1;
    end else if (abort) begin
      m_run = 0; m_idx = 0; m_known = 1;
    end else if (!m_run) begin
      if (key_valid) begin
        m_run = 1; m_sched = expand(key_in); m_idx = 0; m_data = key_in; m_known = 1;
      end
    end else if (rk_ready) begin
      if (m_idx == 10) begin
        m_run = 0; m_known = 0;
      end else begin
        m_idx++;
        m_data = m_sched[m_idx];
      end
    end
    armed = 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [127:0] k);
    int n;
    n = 0;
    key_valid = 1'b1;
    key_in    = k;
    while (!key_ready && n < 100) begin step(); n++; end
    chk("send_key_timeout", 128'(n < 100), 128'(1));
    step();
    key_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (rk_valid && n < 300) begin step(); n++; end
    chk("wait_idle_timeout", 128'(n < 300), 128'(1));
  endtask

  task automatic wait_idx(input logic [3:0] target);
    int n;
    n = 0;
    while (!(rk_valid && rk_idx == target) && n < 100) begin step(); n++; end
    chk("wait_idx_timeout", 128'(n < 100), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    sched_t s;
    int vcount;
    int hs;
    int n;
    logic [127:0] cap1, cap2, cap10;
    logic         last10;

    rst_n = 1'b0; key_valid = 1'b0; key_in = '0; abort = 1'b0; rk_ready = 1'b0;
    step(); step();
    chk("reset_rk_valid", 128'(rk_valid), 128'(0));
    chk("reset_key_ready", 128'(key_ready), 128'(1));
    chk("reset_rk_data", rk_data, 128'h0);
    rst_n = 1'b1;
    step();

    // Pin the model against published values.
    chk("model_sbox_00", 128'(m_sbox(8'h00)), 128'h63);
    chk("model_sbox_53", 128'(m_sbox(8'h53)), 128'hed);
    s = expand(KEY_FIPS);
    chk("model_fips_rk1", s[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_fips_rk10", s[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    s = expand(KEY_ZERO);
    chk("model_zero_rk1", s[1], 128'h62636363626363636263636362636363);
    chk("model_zero_rk2", s[2], 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);

    // 1: FIPS key, no backpressure.
    rk_ready = 1'b1;
    send_key(KEY_FIPS);
    vcount = 0; cap1 = '0; cap10 = '0; last10 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (rk_valid) begin
        vcount++;
        if (rk_idx == 4'd0) chk("t1_rk0", rk_data, KEY_FIPS);
        if (rk_idx == 4'd1) cap1 = rk_data;
        if (rk_idx == 4'd10) begin cap10 = rk_data; last10 = rk_last; end
      end
      step();
    end
    chk("t1_valid_cycles", 128'(vcount), 128'(11));
    chk("t1_rk1", cap1, 128'ha0fafe1788542cb123a339392a6c7605);
    chk("t1_rk10", cap10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("t1_rk_last", 128'(last10), 128'(1));

    // 2: all-zero key.
    send_key(KEY_ZERO);
    cap1 = '0; cap2 = '0;
    for (int i = 0; i < 15; i++) begin
      if (rk_valid && rk_idx == 4'd1) cap1 = rk_data;
      if (rk_valid && rk_idx == 4'd2) cap2 = rk_data;
      step();
    end
    chk("t2_rk1", cap1, 128'h62636363626363636263636362636363);
    chk("t2_rk2", cap2, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);

    // 3: random backpressure.
    rk_ready = 1'b0;
    send_key(KEY_FIPS);
    hs = 0; n = 0;
    while (n < 300) begin
      rk_ready = 1'($urandom_range(0, 1));
      if (rk_valid) chk("t3_key_ready_low", 128'(key_ready), 128'(0));
      if (rk_valid && rk_ready) hs++;
      if (rk_valid && rk_ready && rk_idx == 4'd10) break;
      step();
      n++;
    end
    step();
    chk("t3_handshakes", 128'(hs), 128'(11));
    rk_ready = 1'b1;
    wait_idle();

    // 4: abort at rk_idx 4 together with rk_ready.
    send_key(KEY_FIPS);
    wait_idx(4'd4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_rk_valid", 128'(rk_valid), 128'(0));
    chk("t4_rk_idx", 128'(rk_idx), 128'(0));
    chk("t4_key_ready", 128'(key_ready), 128'(1));
    send_key(KEY_SEQ);
    chk("t4_restart_idx", 128'(rk_idx), 128'(0));
    chk("t4_restart_rk0", rk_data, KEY_SEQ);
    wait_idle();

    // 5: one-cycle reset at rk_idx 7, key_valid held high through it.
    send_key(KEY_FIPS);
    wait_idx(4'd7);
    rst_n = 1'b0; key_valid = 1'b1; key_in = KEY_SEQ;
    step();
    chk("t5_rk_valid", 128'(rk_valid), 128'(0));
    chk("t5_rk_data", rk_data, 128'h0);
    chk("t5_rk_idx", 128'(rk_idx), 128'(0));
    chk("t5_key_ready", 128'(key_ready), 128'(1));
    rst_n = 1'b1;
    step();
    key_valid = 1'b0;
    chk("t5_accept_valid", 128'(rk_valid), 128'(1));
    chk("t5_accept_rk0", rk_data, KEY_SEQ);
    wait_idle();

    // 6: back-to-back keys, key_valid held high.
    send_key(KEY_FIPS);
    key_valid = 1'b1;
    key_in    = KEY_SEQ;
    wait_idx(4'd10);
    chk("t6_rk10", rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    step();
    chk("t6_gap_valid", 128'(rk_valid), 128'(0));
    chk("t6_gap_key_ready", 128'(key_ready), 128'(1));
    step();
    key_valid = 1'b0;
    chk("t6_second_valid", 128'(rk_valid), 128'(1));
    chk("t6_second_idx", 128'(rk_idx), 128'(0));
    chk("t6_second_rk0", rk_data, KEY_SEQ);
    wait_idle();
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
